// File: rtl/rx_ser_par_pkg.sv
// Shared types and sizing for the rx_ser_par serial-to-parallel receiver.
package rx_ser_par_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned WORD_W_DEF  = 4;
  localparam int unsigned N_WORDS_DEF = 4;
  localparam int unsigned FRAME_BITS  = WORD_W_DEF * N_WORDS_DEF;
  localparam int unsigned BC_W        = cnt_w(WORD_W_DEF);
  localparam int unsigned WC_W        = cnt_w(N_WORDS_DEF);

endpackage

// File: rtl/rx_ser_par_shift.sv
// Serial-in/parallel-out word register: writes one addressed bit per enabled cycle.
module ser_par_shift #(
  parameter int unsigned WORD_W = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [IDX_W-1:0]  idx,
  input  logic              din,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q[idx] <= din;
    end
  end

endmodule

// File: rtl/rx_ser_par.sv
// Receive side of the 4-word serial link: deserializes a strobed bit stream into
// words A..D, with a valid pulse on good frames and frame_err on short/overlong ones.
module rx_ser_par
  import rx_ser_par_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned N_WORDS   = N_WORDS_DEF,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rx_data,
  input  logic              rx_active,
  output logic [WORD_W-1:0] A,
  output logic [WORD_W-1:0] B,
  output logic [WORD_W-1:0] C,
  output logic [WORD_W-1:0] D,
  output logic              valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned BCW = cnt_w(WORD_W);
  localparam int unsigned WCW = cnt_w(N_WORDS);
  localparam logic [BCW-1:0] BC_LAST = BCW'(WORD_W - 1);
  localparam logic [WCW-1:0] WC_LAST = WCW'(N_WORDS - 1);

  state_t state, state_n;
  logic [BCW-1:0] bc, bc_n;
  logic [WCW-1:0] wc, wc_n;
  logic ovl, ovl_n;
  logic valid_n, err_n, busy_n;
  logic sample, abort, last;
  logic [BCW-1:0] idx;

  logic [WORD_W-1:0] shadow [N_WORDS];
  logic [WORD_W-1:0] merged [N_WORDS];
  logic [WORD_W-1:0] out_q  [N_WORDS];
  logic [WORD_W-1:0] out_n  [N_WORDS];

  assign idx  = LSB_FIRST ? bc : (BC_LAST - bc);
  assign last = (wc == WC_LAST) && (bc == BC_LAST);

  for (genvar w = 0; w < N_WORDS; w++) begin : g_word
    ser_par_shift #(
      .WORD_W (WORD_W),
      .IDX_W  (BCW)
    ) u_word (
      .clk (clk),
      .clr (clr | abort),
      .en  (sample && (wc == WCW'(w))),
      .idx (idx),
      .din (rx_data),
      .q   (shadow[w])
    );
  end

  // The final bit is still in flight at the commit edge, so merge it into the
  // shadow image before loading the output registers.
  always_comb begin
    for (int unsigned w = 0; w < N_WORDS; w++) begin
      merged[w] = shadow[w];
      if (wc == WCW'(w)) begin
        merged[w][idx] = rx_data;
      end
    end
  end

  always_comb begin
    state_n = state;
    bc_n    = bc;
    wc_n    = wc;
    ovl_n   = ovl;
    valid_n = 1'b0;
    err_n   = 1'b0;
    sample  = 1'b0;
    abort   = 1'b0;
    for (int unsigned w = 0; w < N_WORDS; w++) begin
      out_n[w] = out_q[w];
    end

    case (state)
      IDLE: begin
        ovl_n = 1'b0;
        if (rx_active) begin
          sample  = 1'b1;
          state_n = RECV;
          if (bc == BC_LAST) begin
            bc_n = '0;
            wc_n = wc + 1'b1;
          end else begin
            bc_n = bc + 1'b1;
          end
        end
      end
      RECV: begin
        if (rx_active) begin
          sample = 1'b1;
          if (last) begin
            for (int unsigned w = 0; w < N_WORDS; w++) begin
              out_n[w] = merged[w];
            end
            valid_n = 1'b1;
            bc_n    = '0;
            wc_n    = '0;
            state_n = DRAIN;
          end else if (bc == BC_LAST) begin
            bc_n = '0;
            wc_n = wc + 1'b1;
          end else begin
            bc_n = bc + 1'b1;
          end
        end else begin
          err_n   = 1'b1;
          abort   = 1'b1;
          bc_n    = '0;
          wc_n    = '0;
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (!rx_active) begin
          ovl_n   = 1'b0;
          state_n = IDLE;
        end else if (!ovl) begin
          err_n = 1'b1;
          ovl_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      bc        <= '0;
      wc        <= '0;
      ovl       <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned w = 0; w < N_WORDS; w++) begin
        out_q[w] <= '0;
      end
    end else begin
      state     <= state_n;
      bc        <= bc_n;
      wc        <= wc_n;
      ovl       <= ovl_n;
      valid     <= valid_n;
      frame_err <= err_n;
      busy      <= busy_n;
      for (int unsigned w = 0; w < N_WORDS; w++) begin
        out_q[w] <= out_n[w];
      end
    end
  end

  assign A = out_q[0];
  assign B = out_q[1];
  assign C = out_q[2];
  assign D = out_q[3];

endmodule

// File: tb/tb_rx_ser_par.sv
// Directed self-checking bench for rx_ser_par (LSB-first and MSB-first instances).
module tb_rx_ser_par;
  import rx_ser_par_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic rx_data = 1'b0, rx_active = 1'b0;
  logic rx_data_m = 1'b0, rx_active_m = 1'b0;
  logic [3:0] a, b, c, d, a_m, b_m, c_m, d_m;
  logic valid, busy, frame_err, valid_m, busy_m, frame_err_m;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rx_ser_par #(.WORD_W(4), .N_WORDS(4), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .clr(clr), .rx_data(rx_data), .rx_active(rx_active),
    .A(a), .B(b), .C(c), .D(d),
    .valid(valid), .busy(busy), .frame_err(frame_err)
  );

  rx_ser_par #(.WORD_W(4), .N_WORDS(4), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .clr(clr), .rx_data(rx_data_m), .rx_active(rx_active_m),
    .A(a_m), .B(b_m), .C(c_m), .D(d_m),
    .valid(valid_m), .busy(busy_m), .frame_err(frame_err_m)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // frame = {A,B,C,D}; drives nbits bits, leaving rx_active high if keep is set.
  task automatic send_bits(input logic [15:0] frame, input int unsigned nbits,
                           input bit msb, input bit keep);
    logic [3:0] word;
    logic bit_v;
    for (int unsigned i = 0; i < nbits; i++) begin
      word  = 4'(frame >> (12 - 4 * (i / 4)));
      bit_v = msb ? word[3 - (i % 4)] : word[i % 4];
      if (msb) begin
        rx_active_m = 1'b1;
        rx_data_m   = bit_v;
      end else begin
        rx_active = 1'b1;
        rx_data   = bit_v;
      end
      step();
    end
    if (!keep) begin
      if (msb) begin
        rx_active_m = 1'b0;
        rx_data_m   = 1'b0;
      end else begin
        rx_active = 1'b0;
        rx_data   = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    tests_run++;
    if ({a, b, c, d} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_words: got %h expected 0000", {a, b, c, d});
    end
    tests_run++;
    if ({valid, busy, frame_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 000", {valid, busy, frame_err});
    end
  endtask

  task automatic test_basic();
    send_bits(16'h3A5F, FRAME_BITS, 1'b0, 1'b0);
    tests_run++;
    if ({valid, busy, frame_err} !== 3'b110) begin
      tests_failed++;
      $display("FAIL basic_flags: got %b expected 110", {valid, busy, frame_err});
    end
    tests_run++;
    if ({a, b, c, d} !== 16'h3A5F) begin
      tests_failed++;
      $display("FAIL basic_words: got %h expected 3a5f", {a, b, c, d});
    end
    step();
    tests_run++;
    if ({valid, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_after: valid/busy got %b expected 00", {valid, busy});
    end
  endtask

  task automatic test_short();
    send_bits(16'h1234, 9, 1'b0, 1'b0);
    tests_run++;
    if ({valid, busy, frame_err} !== 3'b010) begin
      tests_failed++;
      $display("FAIL short_mid: got %b expected 010", {valid, busy, frame_err});
    end
    step();
    tests_run++;
    if ({valid, busy, frame_err} !== 3'b001) begin
      tests_failed++;
      $display("FAIL short_err: got %b expected 001", {valid, busy, frame_err});
    end
    tests_run++;
    if ({a, b, c, d} !== 16'h3A5F) begin
      tests_failed++;
      $display("FAIL short_words: got %h expected 3a5f", {a, b, c, d});
    end
    step();
    tests_run++;
    if ({valid, busy, frame_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL short_idle: got %b expected 000", {valid, busy, frame_err});
    end
  endtask

  task automatic test_overlong();
    send_bits(16'hFFFF, FRAME_BITS, 1'b0, 1'b1);
    tests_run++;
    if ({valid, frame_err, a, b, c, d} !== {2'b10, 16'hFFFF}) begin
      tests_failed++;
      $display("FAIL over_commit: got %b/%h expected 10/ffff", {valid, frame_err}, {a, b, c, d});
    end
    rx_data = 1'b0;
    step();
    tests_run++;
    if ({valid, busy, frame_err} !== 3'b011) begin
      tests_failed++;
      $display("FAIL over_err: got %b expected 011", {valid, busy, frame_err});
    end
    step();
    tests_run++;
    if ({valid, busy, frame_err} !== 3'b010) begin
      tests_failed++;
      $display("FAIL over_once: got %b expected 010", {valid, busy, frame_err});
    end
    rx_active = 1'b0;
    step();
    tests_run++;
    if ({busy, frame_err, a, b, c, d} !== {2'b00, 16'hFFFF}) begin
      tests_failed++;
      $display("FAIL over_end: got %b/%h expected 00/ffff", {busy, frame_err}, {a, b, c, d});
    end
  endtask

  task automatic test_back_to_back();
    send_bits(16'h1234, FRAME_BITS, 1'b0, 1'b0);
    tests_run++;
    if ({valid, a, b, c, d} !== {1'b1, 16'h1234}) begin
      tests_failed++;
      $display("FAIL b2b_first: got %b/%h expected 1/1234", valid, {a, b, c, d});
    end
    step();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_gap: valid got %b expected 0", valid);
    end
    send_bits(16'h8421, FRAME_BITS, 1'b0, 1'b0);
    tests_run++;
    if ({valid, frame_err, a, b, c, d} !== {2'b10, 16'h8421}) begin
      tests_failed++;
      $display("FAIL b2b_second: got %b/%h expected 10/8421", {valid, frame_err}, {a, b, c, d});
    end
    step();
  endtask

  task automatic test_reset_mid();
    send_bits(16'hC0DE, 7, 1'b0, 1'b1);
    clr = 1'b1;
    step();
    clr       = 1'b0;
    rx_active = 1'b0;
    tests_run++;
    if ({valid, busy, frame_err, a, b, c, d} !== 19'h0) begin
      tests_failed++;
      $display("FAIL rstmid_clear: got %b/%h expected 000/0000", {valid, busy, frame_err}, {a, b, c, d});
    end
    step();
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_noerr: frame_err got %b expected 0", frame_err);
    end
    send_bits(16'hC0DE, FRAME_BITS, 1'b0, 1'b0);
    tests_run++;
    if ({valid, a, b, c, d} !== {1'b1, 16'hC0DE}) begin
      tests_failed++;
      $display("FAIL rstmid_frame: got %b/%h expected 1/c0de", valid, {a, b, c, d});
    end
    step();
  endtask

  task automatic test_msb_first();
    send_bits(16'h3C96, FRAME_BITS, 1'b1, 1'b0);
    tests_run++;
    if ({valid_m, frame_err_m, a_m, b_m, c_m, d_m} !== {2'b10, 16'h3C96}) begin
      tests_failed++;
      $display("FAIL msb_frame: got %b/%h expected 10/3c96", {valid_m, frame_err_m}, {a_m, b_m, c_m, d_m});
    end
    rx_data_m = 1'bx;
    step();
    step();
    step();
    tests_run++;
    if ({a_m, b_m, c_m, d_m} !== 16'h3C96) begin
      tests_failed++;
      $display("FAIL msb_xhold: got %h expected 3c96", {a_m, b_m, c_m, d_m});
    end
    tests_run++;
    if ({valid_m, busy_m, frame_err_m} !== 3'b000) begin
      tests_failed++;
      $display("FAIL msb_xflags: got %b expected 000", {valid_m, busy_m, frame_err_m});
    end
    rx_data_m = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_overlong();
    test_back_to_back();
    test_reset_mid();
    test_msb_first();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
